// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - cause codes, mip bit positions, FSM states and priority helper
package int_pkg;

    localparam logic [4:0] CAUSE_MSI        = 5'd3;
    localparam logic [4:0] CAUSE_MTI        = 5'd7;
    localparam logic [4:0] CAUSE_MEI        = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

    localparam int MIP_MSI_BIT   = 3;
    localparam int MIP_MTI_BIT   = 7;
    localparam int MIP_MEI_BIT   = 11;
    localparam int MIP_LOCAL_BIT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACTIVE
    } int_state_e;

    // MEI beats MSI beats MTI beats locals; among locals the lowest index wins.
    function automatic logic [4:0] prio_code(input logic [31:0] en);
        logic [4:0] code;
        code = 5'd0;
        for (int b = 31; b >= MIP_LOCAL_BIT; b--) begin
            if (en[b]) code = 5'(b);
        end
        if (en[MIP_MTI_BIT]) code = CAUSE_MTI;
        if (en[MIP_MSI_BIT]) code = CAUSE_MSI;
        if (en[MIP_MEI_BIT]) code = CAUSE_MEI;
        return code;
    endfunction

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// rtl/int_ctrl_irq_sync.sv - multi-bit flop-chain synchroniser, cleared on reset
module irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - machine-mode interrupt controller feeding mip and trap entry to the CSR block
module int_ctrl
    import int_pkg::*;
#(
    parameter int          N_LOCAL     = 4,
    parameter logic [15:0] LOCAL_EDGE  = 16'b0000,
    parameter int          SYNC_STAGES = 2,
    localparam int         LW          = (N_LOCAL > 0) ? N_LOCAL : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ext_irq,
    input  logic          sw_irq,
    input  logic          timer_irq,
    input  logic [LW-1:0] local_irq,
    input  logic [31:0]   mie,
    input  logic          mstatus_mie,
    input  logic          take_ok,
    input  logic          ret_action,
    output logic [31:0]   mip_in,
    output logic          int_req,
    output logic          int_action,
    output logic          hw_int,
    output logic [4:0]    int_code
);

    logic [LW+2:0] synced;
    logic          ext_s;
    logic          sw_s;
    logic          timer_s;
    logic [LW-1:0] loc_s;
    logic [LW-1:0] loc_bits;
    logic [31:0]   enabled;
    logic [4:0]    sel_code;
    logic          want;

    int_state_e    state_q, state_d;
    logic [4:0]    code_q, code_d;

    irq_sync #(
        .WIDTH  (LW + 3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     ({local_irq, timer_irq, sw_irq, ext_irq}),
        .q_o     (synced)
    );

    assign ext_s   = synced[0];
    assign sw_s    = synced[1];
    assign timer_s = synced[2];
    assign loc_s   = synced[LW+2:3];

    if (N_LOCAL > 0) begin : g_local
        localparam logic [N_LOCAL-1:0] EDGE_MASK = LOCAL_EDGE[N_LOCAL-1:0];

        logic [N_LOCAL-1:0] prev_q, pend_q, pend_d;

        // A fresh edge in the take cycle must survive the clear of the old one.
        always_comb begin
            pend_d = pend_q;
            for (int i = 0; i < N_LOCAL; i++) begin
                if (loc_s[i] && !prev_q[i]) begin
                    pend_d[i] = 1'b1;
                end else if (int_action && int_code == CAUSE_LOCAL_BASE + 5'(i)) begin
                    pend_d[i] = 1'b0;
                end
            end
            pend_d = pend_d & EDGE_MASK;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                prev_q <= '0;
                pend_q <= '0;
            end else begin
                prev_q <= loc_s;
                pend_q <= pend_d;
            end
        end

        assign loc_bits = (pend_q & EDGE_MASK) | (loc_s & ~EDGE_MASK);
    end else begin : g_nolocal
        assign loc_bits = '0;
    end

    always_comb begin
        mip_in              = '0;
        mip_in[MIP_MEI_BIT] = ext_s;
        mip_in[MIP_MTI_BIT] = timer_s;
        mip_in[MIP_MSI_BIT] = sw_s;
        for (int i = 0; i < N_LOCAL; i++) begin
            mip_in[MIP_LOCAL_BIT + i] = loc_bits[i];
        end
    end

    assign enabled  = mip_in & mie;
    assign sel_code = prio_code(enabled);
    assign want     = (|enabled) && mstatus_mie;

    // Strobe is Mealy so mepc/mcause capture on the same edge as the state change.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        int_req    = 1'b0;
        int_action = 1'b0;
        int_code   = code_q;
        unique case (state_q)
            IDLE: begin
                if (want) state_d = ARM;
            end
            ARM: begin
                int_req  = 1'b1;
                int_code = sel_code;
                if (!want) begin
                    state_d = IDLE;
                end else if (take_ok) begin
                    int_action = 1'b1;
                    code_d     = sel_code;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ret_action) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hw_int = int_action;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            code_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl: vector table, corner sequences, random vs model
module tb_int_ctrl;

    localparam int          SS        = 2;
    localparam logic [3:0]  EDGE_MASK = 4'b0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ext_irq, sw_irq, timer_irq;
    logic [3:0]  local_irq;
    logic [31:0] mie;
    logic        mstatus_mie, take_ok, ret_action;
    logic [31:0] mip_in;
    logic        int_req, int_action, hw_int;
    logic [4:0]  int_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int_ctrl #(
        .N_LOCAL     (4),
        .LOCAL_EDGE  (16'h0001),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ext_irq     (ext_irq),
        .sw_irq      (sw_irq),
        .timer_irq   (timer_irq),
        .local_irq   (local_irq),
        .mie         (mie),
        .mstatus_mie (mstatus_mie),
        .take_ok     (take_ok),
        .ret_action  (ret_action),
        .mip_in      (mip_in),
        .int_req     (int_req),
        .int_action  (int_action),
        .hw_int      (hw_int),
        .int_code    (int_code)
    );

    typedef struct {
        logic        ext;
        logic        sw;
        logic        tim;
        logic [3:0]  loc;
        logic [31:0] mie;
        logic [31:0] mip;
        logic        req;
        logic [4:0]  code;
    } vec_t;

    vec_t vecs[9];

    // Reference model: raw samples per edge (newest first), pending edge set, handler phase.
    logic [6:0]  hist[$];
    logic [3:0]  m_pend;
    int          m_phase;
    logic [4:0]  m_last;
    int          prio[7] = '{11, 3, 7, 16, 17, 18, 19};
    logic [6:0]  s_now, s_prev;
    logic [31:0] m_mip, m_en;
    int          m_sel;
    bit          m_want, m_act;
    int          strobes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ext_irq = 0; sw_irq = 0; timer_irq = 0; local_irq = 4'b0;
        mie = 32'h0; mstatus_mie = 0; take_ok = 0; ret_action = 0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (int_req !== 1'b1 && k < 12) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, int_req, 1);
    endtask

    task automatic pulse_ret();
        @(negedge clk); ret_action = 1;
        @(negedge clk); ret_action = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 0;
        @(negedge clk);
        @(negedge clk); reset_n = 1;
    endtask

    function automatic logic [6:0] synced_at(input int age);
        if (hist.size() > age) return hist[age];
        return 7'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 4'b0000, 32'h0000_0888, 32'h0000_0888, 1'b1, 5'd11};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 4'b0000, 32'h0000_0088, 32'h0000_0888, 1'b1, 5'd3};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 4'b0000, 32'h0000_0080, 32'h0000_0888, 1'b1, 5'd7};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 4'b1110, 32'h000E_0000, 32'h000E_0000, 1'b1, 5'd17};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 4'b1000, 32'h0008_0080, 32'h0008_0080, 1'b1, 5'd7};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 4'b1100, 32'h000C_0000, 32'h000C_0000, 1'b1, 5'd18};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 4'b0010, 32'h0002_0800, 32'h0002_0800, 1'b1, 5'd11};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 4'b0010, 32'h0002_0008, 32'h0002_0008, 1'b1, 5'd3};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 5'd11};

        // Reset state, with a live request held at the pins.
        drive_idle();
        reset_n = 0;
        ext_irq = 1; mie = 32'h800; mstatus_mie = 1; take_ok = 1;
        cycles(3);
        chk("rst_mip", mip_in, 0);
        chk("rst_req", int_req, 0);
        chk("rst_action", int_action, 0);
        chk("rst_hw_int", hw_int, 0);
        chk("rst_code", int_code, 0);
        drive_idle();
        @(negedge clk); reset_n = 1;

        // External pulse: sync latency, single strobe, no retake until mret.
        @(negedge clk);
        mie = 32'h800; mstatus_mie = 1; take_ok = 1; ext_irq = 1;
        #1;
        chk("ext_mip_t0", mip_in, 0);
        cycles(1);
        chk("ext_mip_t1", mip_in, 0);
        cycles(1);
        chk("ext_mip_t2", mip_in, 32'h800);
        chk("ext_req_t2", int_req, 0);
        cycles(1);
        chk("ext_req_t3", int_req, 1);
        chk("ext_action_t3", int_action, 1);
        chk("ext_hw_int_t3", hw_int, 1);
        chk("ext_code_t3", int_code, 11);
        cycles(1);
        chk("ext_action_t4", int_action, 0);
        chk("ext_code_held", int_code, 11);
        @(negedge clk); ext_irq = 0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (int_action === 1'b1) strobes++;
        end
        chk("ext_no_restrobe", strobes, 0);
        pulse_ret();
        cycles(3);
        chk("ext_idle_after_ret", int_req, 0);

        // Priority vector table, all held in ARM with take_ok low.
        take_ok = 0;
        foreach (vecs[v]) begin
            @(negedge clk);
            ext_irq = vecs[v].ext; sw_irq = vecs[v].sw; timer_irq = vecs[v].tim;
            local_irq = vecs[v].loc; mie = vecs[v].mie; mstatus_mie = 1;
            cycles(5);
            chk($sformatf("vec%0d_mip", v), mip_in, vecs[v].mip);
            chk($sformatf("vec%0d_req", v), int_req, vecs[v].req);
            chk($sformatf("vec%0d_code", v), int_code, vecs[v].code);
            chk($sformatf("vec%0d_action", v), int_action, 0);
        end
        @(negedge clk); drive_idle();
        cycles(4);

        // Late higher-priority request overtakes a waiting timer.
        @(negedge clk);
        mie = 32'h888; mstatus_mie = 1; timer_irq = 1;
        wait_req("late_arm");
        chk("late_code_mti", int_code, 7);
        @(negedge clk); ext_irq = 1;
        cycles(3);
        chk("late_code_mei", int_code, 11);
        chk("late_no_action", int_action, 0);
        @(negedge clk); take_ok = 1;
        #1;
        chk("late_action", int_action, 1);
        chk("late_take_code", int_code, 11);
        @(negedge clk); take_ok = 0; ext_irq = 0; timer_irq = 0;
        pulse_ret();
        cycles(4);

        // Withdrawal by line drop: back to IDLE with no strobe.
        @(negedge clk);
        mie = 32'h80; mstatus_mie = 1; timer_irq = 1;
        wait_req("wd_arm");
        @(negedge clk); timer_irq = 0;
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (int_action === 1'b1) strobes++;
        end
        chk("wd_no_strobe", strobes, 0);
        chk("wd_idle", int_req, 0);

        // Withdrawal by mstatus.MIE in the same cycle as take_ok.
        @(negedge clk); timer_irq = 1;
        wait_req("wd2_arm");
        @(negedge clk); mstatus_mie = 0; take_ok = 1;
        #1;
        chk("wd2_no_action", int_action, 0);
        @(negedge clk); take_ok = 0; #1;
        chk("wd2_idle", int_req, 0);
        mstatus_mie = 1;
        wait_req("wd2_rearm");
        take_ok = 1; #1;
        chk("wd2_take", int_action, 1);
        chk("wd2_take_code", int_code, 7);
        @(negedge clk); take_ok = 0; timer_irq = 0;
        pulse_ret();
        cycles(4);

        // Edge-latched local line 0.
        @(negedge clk);
        mie = 32'h1_0000; mstatus_mie = 1; local_irq = 4'b0001;
        @(negedge clk); local_irq = 4'b0000;
        wait_req("loc_arm");
        chk("loc_code", int_code, 16);
        cycles(3);
        chk("loc_mip_held", mip_in & 32'h1_0000, 32'h1_0000);
        take_ok = 1; #1;
        chk("loc_take", int_action, 1);
        @(negedge clk); take_ok = 0; #1;
        chk("loc_mip_cleared", mip_in & 32'h1_0000, 0);
        chk("loc_req_after_take", int_req, 0);
        pulse_ret();
        @(negedge clk); local_irq = 4'b0001;
        @(negedge clk); local_irq = 4'b0000;
        wait_req("loc_arm2");
        cycles(2);
        local_irq = 4'b0001;
        @(negedge clk); local_irq = 4'b0000;
        @(negedge clk); take_ok = 1; #1;
        chk("loc_take2", int_action, 1);
        chk("loc_take2_code", int_code, 16);
        @(negedge clk); take_ok = 0; #1;
        chk("loc_edge_on_take_kept", mip_in & 32'h1_0000, 32'h1_0000);

        // Asynchronous reset while ACTIVE, then level re-arm after sync.
        @(negedge clk);
        drive_idle();
        ext_irq = 1; mie = 32'h800; mstatus_mie = 1;
        pulse_ret();
        cycles(4);
        take_ok = 1;
        wait_req("ra_arm");
        @(negedge clk); take_ok = 0; #1;
        chk("ra_active_code", int_code, 11);
        #1 reset_n = 0;
        #1;
        chk("ra_mip", mip_in, 0);
        chk("ra_req", int_req, 0);
        chk("ra_action", int_action, 0);
        chk("ra_hw_int", hw_int, 0);
        chk("ra_code", int_code, 0);
        @(negedge clk); reset_n = 1;
        cycles(1);
        chk("ra_mip_t1", mip_in, 0);
        cycles(1);
        chk("ra_mip_t2", mip_in, 32'h800);
        chk("ra_req_t2", int_req, 0);
        cycles(1);
        chk("ra_req_t3", int_req, 1);

        // Randomised run against the reference model.
        drive_idle();
        do_reset();
        hist.delete();
        m_pend = 4'b0; m_phase = 0; m_last = 5'd0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(7) == 0) sw_irq = ~sw_irq;
            if ($urandom_range(7) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(3) == 0) local_irq = local_irq ^ 4'($urandom);
            if (c == 0 || $urandom_range(15) == 0) mie = $urandom;
            mstatus_mie = ($urandom_range(7) != 0);
            take_ok     = ($urandom_range(2) == 0);
            ret_action  = ($urandom_range(3) == 0);
            #1;

            s_now  = synced_at(SS - 1);
            s_prev = synced_at(SS);
            m_mip = 32'h0;
            m_mip[11] = s_now[0];
            m_mip[3]  = s_now[1];
            m_mip[7]  = s_now[2];
            for (int i = 0; i < 4; i++)
                m_mip[16 + i] = EDGE_MASK[i] ? m_pend[i] : s_now[3 + i];
            m_en  = m_mip & mie;
            m_sel = -1;
            for (int j = 0; j < 7; j++)
                if (m_sel < 0 && m_en[prio[j]]) m_sel = prio[j];
            m_want = (m_sel >= 0) && mstatus_mie;
            m_act  = (m_phase == 1) && m_want && take_ok;

            chk($sformatf("rnd_mip@%0d", c), mip_in, m_mip);
            chk($sformatf("rnd_req@%0d", c), int_req, (m_phase == 1) ? 1 : 0);
            chk($sformatf("rnd_action@%0d", c), int_action, m_act ? 1 : 0);
            chk($sformatf("rnd_hw_int@%0d", c), hw_int, m_act ? 1 : 0);
            if (m_phase != 1)
                chk($sformatf("rnd_code_held@%0d", c), int_code, m_last);
            else if (m_sel >= 0)
                chk($sformatf("rnd_code@%0d", c), int_code, m_sel);

            for (int i = 0; i < 4; i++) begin
                if (EDGE_MASK[i]) begin
                    if (s_now[3 + i] && !s_prev[3 + i]) m_pend[i] = 1'b1;
                    else if (m_act && m_sel == 16 + i) m_pend[i] = 1'b0;
                end
            end
            case (m_phase)
                0: if (m_want) m_phase = 1;
                1: begin
                    if (!m_want) m_phase = 0;
                    else if (take_ok) begin
                        m_phase = 2;
                        m_last  = 5'(m_sel);
                    end
                end
                default: if (ret_action) m_phase = 0;
            endcase
            hist.push_front({local_irq, timer_irq, sw_irq, ext_irq});
            if (hist.size() > SS + 1) void'(hist.pop_back());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
